rr_bus_arbiter: RTL and testbench

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

---
 rtl/rr_bus_arbiter_if.sv | 47 ++++
 rtl/rr_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_rr_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// rr_bus_arbiter_if
// Bundles the per-core request/access signals and the shared data-memory
// port served by rr_bus_arbiter.
// Revision: 1.0
// ============================================================================
interface rr_bus_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  // core side
  logic [N_CORES-1:0]        D_Bus_RQ;
  logic [N_CORES-1:0]        Core_Read;
  logic [N_CORES*BE_W-1:0]   Core_Write;
  logic [N_CORES*ADDR_W-1:0] Core_Address;
  logic [N_CORES*DATA_W-1:0] Core_WData;
  logic [N_CORES-1:0]        D_Bus_GRANT;

  // memory side
  logic                      DataMem_Ready;
  logic                      DataMem_Read;
  logic [BE_W-1:0]           DataMem_Write;
  logic [ADDR_W-1:0]         DataMem_Address;
  logic [DATA_W-1:0]         DataMem_Out;
  logic                      Arb_Timeout;

  // cores and memory: drive requests and ready, observe grant and the bus
  modport master (
    output D_Bus_RQ, Core_Read, Core_Write, Core_Address, Core_WData,
    output DataMem_Ready,
    input  D_Bus_GRANT, DataMem_Read, DataMem_Write, DataMem_Address,
    input  DataMem_Out, Arb_Timeout
  );

  // arbiter: observes requests and ready, drives grant and the bus
  modport slave (
    input  D_Bus_RQ, Core_Read, Core_Write, Core_Address, Core_WData,
    input  DataMem_Ready,
    output D_Bus_GRANT, DataMem_Read, DataMem_Write, DataMem_Address,
    output DataMem_Out, Arb_Timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// rr_bus_arbiter
// Round-robin arbiter giving N_CORES cores exclusive use of one data-memory
// port. Non-preemptive: the owner keeps the bus until it drops its request.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module rr_bus_arbiter #(
  parameter int N_CORES     = 4,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clock,
  input  logic           reset,
  rr_bus_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int OW   = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  if (N_CORES < 2 || N_CORES > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535 ||
      (DATA_W % 8) != 0) begin : g_param_check
    $error("rr_bus_arbiter: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [OW-1:0] owner, owner_nx;
  logic [OW-1:0] last_win, last_win_nx;
  logic [OW-1:0] pick;
  logic          found;
  logic          owner_rq;
  logic          timeout_hit;

  assign owner_rq = bus.D_Bus_RQ[owner];

  // first requester scanning upward from the core after the last winner
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_CORES; i++) begin
      if (!found && bus.D_Bus_RQ[(int'(last_win) + i) % N_CORES]) begin
        found = 1'b1;
        pick  = OW'((int'(last_win) + i) % N_CORES);
      end
    end
  end

  // state, owner and rotation pointer registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      last_win <= OW'(N_CORES - 1);
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last_win <= last_win_nx;
    end
  end

  // next state: an owner dropping its request always releases the bus,
  // even if memory completes in the same cycle
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_win_nx = last_win;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = ACCESS;
          owner_nx = pick;
        end
      end
      ACCESS: begin
        if (!owner_rq) begin
          state_nx    = IDLE;
          last_win_nx = owner;
        end else if (bus.DataMem_Ready || timeout_hit) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!owner_rq) begin
          state_nx    = IDLE;
          last_win_nx = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // grant follows ownership; memory strobes only while the access is open
  always_comb begin
    bus.D_Bus_GRANT     = '0;
    bus.DataMem_Read    = 1'b0;
    bus.DataMem_Write   = '0;
    bus.DataMem_Address = '0;
    bus.DataMem_Out     = '0;
    if (state != IDLE) begin
      bus.D_Bus_GRANT[owner] = 1'b1;
    end
    if (state == ACCESS) begin
      bus.DataMem_Read    = bus.Core_Read[owner];
      bus.DataMem_Write   = bus.Core_Write[int'(owner)*BE_W +: BE_W];
      bus.DataMem_Address = bus.Core_Address[int'(owner)*ADDR_W +: ADDR_W];
      bus.DataMem_Out     = bus.Core_WData[int'(owner)*DATA_W +: DATA_W];
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wd_cnt;
  logic        timeout_q;
  logic        timeout_nx;

  assign timeout_hit = (wd_cnt == TO_LAST);
  assign timeout_nx  = (state == ACCESS) && owner_rq && !bus.DataMem_Ready &&
                       timeout_hit;

  // watchdog: ACCESS is only entered from IDLE, so clearing in IDLE
  // starts every access at zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_nx;
      if (state == IDLE) begin
        wd_cnt <= '0;
      end else if (state == ACCESS && !bus.DataMem_Ready) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end

  assign bus.Arb_Timeout = timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.Arb_Timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rr_bus_arbiter
// Directed stimulus for rr_bus_arbiter with a transaction-level model that
// is compared against the DUT every cycle, plus literal expectations.
// A second, 3-core instance covers asynchronous reset mid-access.
// Revision: 1.0
// ============================================================================
module tb_rr_bus_arbiter;
  localparam int N   = 4;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TO  = 8;

  logic clock;
  logic reset;
  logic reset3;

  int checks = 0;
  int errors = 0;

  rr_bus_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  rr_bus_arbiter_if #(.N_CORES(3), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  rr_bus_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  rr_bus_arbiter #(.N_CORES(3), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut3 (
    .clock(clock), .reset(reset3), .bus(bus3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ------------------------------------------------------------------
  // Transaction model: who owns the bus, whether its access has
  // completed, and who was served last.
  // ------------------------------------------------------------------
  int m_owner;   // -1 when the bus is free
  bit m_done;
  int m_last;
  int m_wait;    // not-ready cycles seen in the current access
  bit m_pulse;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_owner = -1;
      m_done  = 1'b0;
      m_last  = N - 1;
      m_wait  = 0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (bus.D_Bus_RQ[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            m_done  = 1'b0;
            m_wait  = 0;
            break;
          end
        end
      end else if (!bus.D_Bus_RQ[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (!m_done) begin
        if (bus.DataMem_Ready) begin
          m_done = 1'b1;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (m_wait == TO - 1) begin
            m_done  = 1'b1;
            m_pulse = 1'b1;
          end else begin
            m_wait++;
          end
`endif
        end
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clock) begin
    logic [N-1:0]  e_grant;
    logic          e_rd;
    logic [BW-1:0] e_wr;
    logic [AW-1:0] e_ad;
    logic [DW-1:0] e_dt;
    e_grant = '0;
    e_rd    = 1'b0;
    e_wr    = '0;
    e_ad    = '0;
    e_dt    = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (!m_done) begin
        e_rd = bus.Core_Read[m_owner];
        e_wr = bus.Core_Write[m_owner*BW +: BW];
        e_ad = bus.Core_Address[m_owner*AW +: AW];
        e_dt = bus.Core_WData[m_owner*DW +: DW];
      end
    end
    check("model_grant", 64'(bus.D_Bus_GRANT), 64'(e_grant));
    check("model_read",  64'(bus.DataMem_Read), 64'(e_rd));
    check("model_write", 64'(bus.DataMem_Write), 64'(e_wr));
    check("model_addr",  64'(bus.DataMem_Address), 64'(e_ad));
    check("model_data",  64'(bus.DataMem_Out), 64'(e_dt));
    check("model_tmo",   64'(bus.Arb_Timeout), 64'(m_pulse));
  end

  task automatic do_reset();
    reset = 1'b0;
    bus.D_Bus_RQ      = '0;
    bus.DataMem_Ready = 1'b0;
    tick();
    tick();
    check("reset_grant", 64'(bus.D_Bus_GRANT), 64'h0);
    check("reset_read",  64'(bus.DataMem_Read), 64'h0);
    reset = 1'b1;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    int n;
    n = 0;
    while (bus.D_Bus_GRANT == '0 && n < 20) begin
      tick();
      n++;
    end
    if (bus.D_Bus_GRANT == '0) begin
      checks++;
      errors++;
      $display("FAIL grant_wait no grant within 20 cycles at %0t", $time);
    end
    g = bus.D_Bus_GRANT;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] seq [5];
    int           who [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;
    who[0] = 0; who[1] = 1; who[2] = 2; who[3] = 3; who[4] = 0;

    reset  = 1'b0;
    reset3 = 1'b0;
    bus.Core_Read = 4'b0101;
    bus3.Core_Read = 3'b011;
    bus3.D_Bus_RQ = '0;
    bus3.DataMem_Ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.Core_Write[i*BW +: BW]   = BW'(1 << i);
      bus.Core_Address[i*AW +: AW] = AW'(32'h1000 + i);
      bus.Core_WData[i*DW +: DW]   = 32'hA000_0000 + i;
    end
    for (int i = 0; i < 3; i++) begin
      bus3.Core_Write[i*BW +: BW]   = BW'(4'hF);
      bus3.Core_Address[i*AW +: AW] = AW'(32'h2000 + i);
      bus3.Core_WData[i*DW +: DW]   = 32'hB000_0000 + i;
    end

    // single transaction from core 0
    do_reset();
    tick();
    bus.D_Bus_RQ = 4'b0001;
    tick();
    check("t1_grant",  64'(bus.D_Bus_GRANT), 64'h1);
    check("t1_read",   64'(bus.DataMem_Read), 64'h1);
    check("t1_write",  64'(bus.DataMem_Write), 64'h1);
    check("t1_addr",   64'(bus.DataMem_Address), 64'h1000);
    check("t1_data",   64'(bus.DataMem_Out), 64'hA000_0000);
    bus.DataMem_Ready = 1'b1;
    tick();
    bus.DataMem_Ready = 1'b0;
    check("t1_done_grant", 64'(bus.D_Bus_GRANT), 64'h1);
    check("t1_done_read",  64'(bus.DataMem_Read), 64'h0);
    check("t1_done_addr",  64'(bus.DataMem_Address), 64'h0);
    bus.D_Bus_RQ = 4'b0000;
    tick();
    check("t1_release", 64'(bus.D_Bus_GRANT), 64'h0);

    // all cores requesting continuously: strict rotation
    do_reset();
    bus.D_Bus_RQ = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant(g);
      check("rr_order", 64'(g), 64'(seq[t]));
      bus.DataMem_Ready = 1'b1;
      tick();
      bus.DataMem_Ready = 1'b0;
      tick();
      bus.D_Bus_RQ[who[t]] = 1'b0;
      tick();
      check("rr_gap", 64'(bus.D_Bus_GRANT), 64'h0);
      bus.D_Bus_RQ[who[t]] = 1'b1;
    end
    bus.D_Bus_RQ = 4'b0000;
    tick();
    tick();

    // no preemption of core 1 by core 0
    do_reset();
    bus.D_Bus_RQ = 4'b0010;
    tick();
    check("np_grant1", 64'(bus.D_Bus_GRANT), 64'h2);
    bus.D_Bus_RQ = 4'b0011;
    tick();
    tick();
    tick();
    check("np_hold", 64'(bus.D_Bus_GRANT), 64'h2);
    bus.DataMem_Ready = 1'b1;
    tick();
    bus.DataMem_Ready = 1'b0;
    check("np_done", 64'(bus.D_Bus_GRANT), 64'h2);
    bus.D_Bus_RQ = 4'b0001;
    tick();
    check("np_idle", 64'(bus.D_Bus_GRANT), 64'h0);
    tick();
    check("np_grant0", 64'(bus.D_Bus_GRANT), 64'h1);

    // abort wins over simultaneous ready
    bus.D_Bus_RQ = 4'b0000;
    bus.DataMem_Ready = 1'b1;
    tick();
    bus.DataMem_Ready = 1'b0;
    check("abort_idle", 64'(bus.D_Bus_GRANT), 64'h0);
    bus.D_Bus_RQ = 4'b0011;
    tick();
    check("abort_next", 64'(bus.D_Bus_GRANT), 64'h2);
    bus.D_Bus_RQ = 4'b0000;
    tick();
    check("abort_clear", 64'(bus.D_Bus_GRANT), 64'h0);

    // memory never ready
    bus.D_Bus_RQ = 4'b0100;
    tick();
    check("wd_grant", 64'(bus.D_Bus_GRANT), 64'h4);
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      tick();
      check("wd_wait_read", 64'(bus.DataMem_Read), 64'h1);
      check("wd_wait_tmo",  64'(bus.Arb_Timeout), 64'h0);
    end
    tick();
    check("wd_pulse",      64'(bus.Arb_Timeout), 64'h1);
    check("wd_read_drop",  64'(bus.DataMem_Read), 64'h0);
    check("wd_grant_hold", 64'(bus.D_Bus_GRANT), 64'h4);
    tick();
    check("wd_pulse_end",  64'(bus.Arb_Timeout), 64'h0);
`else
    for (int k = 0; k < 20; k++) tick();
    check("hold_grant", 64'(bus.D_Bus_GRANT), 64'h4);
    check("hold_read",  64'(bus.DataMem_Read), 64'h1);
    check("hold_tmo",   64'(bus.Arb_Timeout), 64'h0);
`endif
    bus.D_Bus_RQ = 4'b0000;
    tick();
    check("wd_release", 64'(bus.D_Bus_GRANT), 64'h0);

    // 3-core instance: asynchronous reset during ACCESS
    reset3 = 1'b1;
    bus3.D_Bus_RQ = 3'b001;
    tick();
    check("r3_grant", 64'(bus3.D_Bus_GRANT), 64'h1);
    check("r3_read",  64'(bus3.DataMem_Read), 64'h1);
    check("r3_addr",  64'(bus3.DataMem_Address), 64'h2000);
    #2;
    reset3 = 1'b0;
    #1;
    check("r3_async_grant", 64'(bus3.D_Bus_GRANT), 64'h0);
    check("r3_async_read",  64'(bus3.DataMem_Read), 64'h0);
    check("r3_async_write", 64'(bus3.DataMem_Write), 64'h0);
    check("r3_async_addr",  64'(bus3.DataMem_Address), 64'h0);
    check("r3_async_data",  64'(bus3.DataMem_Out), 64'h0);
    bus3.D_Bus_RQ = 3'b110;
    tick();
    reset3 = 1'b1;
    tick();
    check("r3_after", 64'(bus3.D_Bus_GRANT), 64'h2);
    bus3.D_Bus_RQ = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
